// File: rtl/puf_pkg.sv
// Shared types and defaults for the PUF response sequencing controller.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        NEXT,
        DONE
    } state_e;

    localparam int unsigned CHALL_W     = 8;
    localparam int unsigned N_BITS_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 1023;

endpackage

// File: rtl/puf_timer.sv
// Per-bit RUN cycle counter for the PUF controller; saturates instead of wrapping.
module puf_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        inc_i,
    input  logic [15:0] limit_i,
    output logic        expired_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_next;

    assign cnt_next  = {1'b0, cnt_q} + 17'd1;
    // Fires on the cycle whose increment brings the count up to the limit.
    assign expired_o = inc_i && (cnt_next >= {1'b0, limit_i});

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_next[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/puf_seq_ctrl.sv
// Sequences a PUF bit cell through N_BITS challenges and collects the responses
// into a word, flagging any bit that failed to resolve within TIMEOUT cycles.
module puf_seq_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned N_BITS  = N_BITS_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [CHALL_W-1:0] seed_i,
    input  logic               bit_resp_i,
    input  logic               bit_finish_i,
    output logic               bit_en_o,
    output logic               bit_rst_o,
    output logic [CHALL_W-1:0] chall_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [N_BITS-1:0]  resp_word_o,
    output logic               timeout_err_o
);

    localparam int unsigned IDX_W = 5;

    state_e             state_q, state_d;
    logic [CHALL_W-1:0] seed_q, seed_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_BITS-1:0]  shift_q, shift_d;
    logic [N_BITS-1:0]  resp_q, resp_d;
    logic [CHALL_W-1:0] chall_q, chall_d;
    logic               err_q, err_d;
    logic               bit_en_q, bit_en_d;
    logic               bit_rst_q, bit_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tmr_expired;

    // Counter is held clear outside RUN so every RUN phase starts from zero.
    puf_timer u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q != RUN),
        .inc_i     (state_q == RUN),
        .limit_i   (16'(TIMEOUT)),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    seed_d  = seed_i;
                    idx_d   = '0;
                    shift_d = '0;
                    err_d   = 1'b0;
                    state_d = ARM;
                end
            end
            ARM: state_d = RUN;
            RUN: begin
                // A real result beats a simultaneous timeout.
                if (bit_finish_i) begin
                    shift_d = N_BITS'({shift_q, bit_resp_i});
                    state_d = NEXT;
                end else if (tmr_expired) begin
                    shift_d = N_BITS'({shift_q, 1'b0});
                    err_d   = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = (idx_q == IDX_W'(N_BITS - 1)) ? DONE : ARM;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        resp_d    = (state_d == DONE) ? shift_q : resp_q;
        chall_d   = (state_d == ARM) ? (seed_d + CHALL_W'(idx_d)) : chall_q;
        bit_en_d  = (state_d == RUN);
        bit_rst_d = (state_d == IDLE) || (state_d == ARM) || (state_d == DONE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            seed_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            resp_q    <= '0;
            chall_q   <= '0;
            err_q     <= 1'b0;
            bit_en_q  <= 1'b0;
            bit_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            resp_q    <= resp_d;
            chall_q   <= chall_d;
            err_q     <= err_d;
            bit_en_q  <= bit_en_d;
            bit_rst_q <= bit_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bit_en_o      = bit_en_q;
    assign bit_rst_o     = bit_rst_q;
    assign chall_o       = chall_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign resp_word_o   = resp_q;
    assign timeout_err_o = err_q;

endmodule

// File: doc/puf_seq_ctrl.md
PUF_SEQ_CTRL -- requirements
Module: puf_seq_ctrl

Interface
REQ-001 Parameter N_BITS, default 8: number of response bits collected per run, range 1..16.
REQ-002 Parameter TIMEOUT, default 1023: maximum RUN cycles per bit before abort, range 1..65535.
REQ-003 clk  in  1  single system clock for all state.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  run request, sampled only in IDLE.
REQ-006 seed  in  8  base challenge, captured when start is accepted.
REQ-007 bit_resp  in  1  response from PUF bit cell.
REQ-008 bit_finish  in  1  PUF bit cell result valid.
REQ-009 bit_en  out  1  enables PUF bit cell ring oscillators.
REQ-010 bit_rst  out  1  clears PUF bit cell counters and arbiter.
REQ-011 chall  out  8  challenge to PUF bit cell; [7:4] selects array-2 RO, [3:0] selects array-1 RO.
REQ-012 busy  out  1  high from start acceptance until DONE exits.
REQ-013 done  out  1  one-cycle pulse when resp_word is updated.
REQ-014 resp_word  out  N_BITS  collected response word.
REQ-015 timeout_err  out  1  sticky flag: at least one bit timed out in the last run.

Function
REQ-016 FSM states SHALL be IDLE, ARM, RUN, NEXT and DONE; all outputs SHALL be registered.
REQ-017 In IDLE, start=1 SHALL do four things: latch seed, clear bit index i, clear shift register, clear timeout_err; next state is ARM.
REQ-018 In IDLE, start=0 SHALL hold the state; start while busy SHALL be ignored.
REQ-019 ARM SHALL last exactly 1 cycle with bit_rst=1, bit_en=0 and chall=seed+i (mod 256, 8-bit wrap); next state is RUN.
REQ-020 RUN SHALL drive bit_en=1 and bit_rst=0, hold chall stable, and increment the timeout counter each cycle.
REQ-021 In RUN, bit_finish=1 SHALL shift bit_resp into the shift register LSB (earlier bits move toward MSB); next state is NEXT.
REQ-022 In RUN, timeout counter reaching TIMEOUT without bit_finish SHALL shift in 0 and set timeout_err; next state is NEXT.
REQ-023 If bit_finish and timeout coincide, bit_finish SHALL win: bit_resp is shifted in and timeout_err is not set.
REQ-024 NEXT SHALL drive bit_en=0 and increment i; if i was N_BITS-1, next state is DONE, else ARM.
REQ-025 DONE SHALL last 1 cycle and load resp_word from the shift register, pulse done=1 and drop busy on exit; next state is IDLE.
REQ-026 resp_word and timeout_err SHALL hold their values until the next DONE, next accepted start (timeout_err only), or reset.
REQ-027 Per-bit latency SHALL be 3+k cycles (ARM 1, RUN k+1 including the finish cycle, NEXT 1), where k is the number of RUN cycles before bit_finish is seen.
REQ-028 The timeout counter SHALL clear on entry to RUN and SHALL NOT wrap.
REQ-029 bit_finish outside RUN SHALL be ignored.

Reset
REQ-030 rst=1 SHALL, at the next clk edge, force the following values: state=IDLE; bit_en=0, bit_rst=1, chall=0, busy=0, done=0, resp_word=0, timeout_err=0, i=0; counters and shift register cleared.
REQ-031 rst asserted mid-run SHALL abort the run with no done pulse, and resp_word SHALL read 0.
REQ-032 bit_rst SHALL remain 1 while rst=1 so the PUF cell resets with the controller.

Structure
REQ-033 A shared package puf_pkg SHALL hold three items: the FSM state type, the challenge width constant (8), and the N_BITS/TIMEOUT defaults.
REQ-034 The timeout counter SHALL be one sub-module, puf_timer, with inputs clear, inc and limit and output expired.

Verification
REQ-035 N_BITS=8, seed=0x10, model finishes after 5 RUN cycles with bit_resp pattern 1,0,1,1,0,0,1,0 -> resp_word=0xB2, done once, 64 cycles start-to-done, chall sequence 0x10..0x17.
REQ-036 seed=0xFE, N_BITS=4 -> chall sequence 0xFE,0xFF,0x00,0x01 (wrap-around).
REQ-037 TIMEOUT=8, bit 2 never finishes, other bits return 1 -> resp_word=0xDF, timeout_err=1; the bit-2 RUN phase lasts exactly 8 cycles.
REQ-038 bit_finish on the same cycle the timeout counter reaches TIMEOUT, bit_resp=1 -> bit captured as 1, timeout_err=0.
REQ-039 start pulsed again during RUN -> ignored, single done; rst asserted in RUN of bit 3 -> next cycle IDLE, busy=0, resp_word=0, no done.
REQ-040 Every ARM cycle SHALL show bit_rst=1 and bit_en=0 (assertion checked throughout all tests).
